// File: rtl/hex8_disp_arbiter.sv
// hex8_disp_arbiter: time-shares one 8-digit hex display between three
// requesters. Arbitration is round-robin. Each owner keeps the display for a
// minimum dwell, and the display is blanked for a fixed interval before every
// SHOW.
//
// Handshake: req[i] is a level request. gnt is one-hot (or zero) and names the
// current owner. An owner keeps its grant for as long as it holds req[i] and
// nobody else is waiting past the dwell. Dropping req[i] gives up the grant on
// the next edge.
module hex8_disp_arbiter #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int BLANK_CYCLES = 50000,
  parameter int CNT_W        = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  output logic [2:0]  gnt,
  output logic        disp_en,
  output logic [31:0] disp_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t             state_q, state_d;
  logic [1:0]         last_q, last_d;
  logic [1:0]         owner_q, owner_d;
  logic [2:0]         gnt_d;
  logic               en_d;
  logic [31:0]        data_d;
  logic [CNT_W-1:0]   blank_q, blank_d;
  logic [CNT_W-1:0]   dwell_q, dwell_d;

  logic               win_found;
  logic [1:0]         win_idx;
  logic [1:0]         cand1, cand2;
  logic [31:0]        owner_data;
  logic               owner_req;
  logic               others_req;
  logic               dwell_done;
  logic               blank_done;

  // Round-robin winner: search last+1, last+2, then last itself.
  always_comb begin
    cand1     = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    cand2     = (cand1  == 2'd2) ? 2'd0 : cand1 + 2'd1;
    win_found = |req;
    win_idx   = last_q;
    if (req[cand1])      win_idx = cand1;
    else if (req[cand2]) win_idx = cand2;
  end

  // Per-owner helpers: the owner's request, its data, and competing requests.
  always_comb begin
    owner_req  = req[owner_q];
    others_req = |(req & ~gnt);
    dwell_done = (dwell_q == CNT_W'(DWELL_CYCLES - 1));
    blank_done = (blank_q == CNT_W'(BLANK_CYCLES - 1));
    case (owner_q)
      2'd0:    owner_data = data0;
      2'd1:    owner_data = data1;
      default: owner_data = data2;
    endcase
  end

  // Next-state and next-output logic for the IDLE/BLANK/SHOW sequence.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    gnt_d   = gnt;
    en_d    = disp_en;
    data_d  = disp_data;
    blank_d = blank_q;
    dwell_d = dwell_q;
    case (state_q)
      IDLE: begin
        en_d = 1'b0;
        if (win_found) begin
          state_d = BLANK;
          owner_d = win_idx;
          last_d  = win_idx;
          gnt_d   = 3'b001 << win_idx;
          blank_d = '0;
        end
      end
      BLANK: begin
        en_d    = 1'b0;
        blank_d = blank_q + CNT_W'(1);
        if (!owner_req) begin
          state_d = IDLE;
          gnt_d   = 3'b000;
        end else if (blank_done) begin
          state_d = SHOW;
          dwell_d = '0;
          en_d    = 1'b1;
          data_d  = owner_data;
        end
      end
      SHOW: begin
        // The display follows the owner's live value on every SHOW cycle.
        en_d    = 1'b1;
        data_d  = owner_data;
        dwell_d = dwell_done ? dwell_q : dwell_q + CNT_W'(1);
        // Release wins over dwell expiry; both re-arbitrate the same way
        // because the owner, being last, is searched last.
        if (!owner_req || (dwell_done && others_req)) begin
          en_d = 1'b0;
          if (win_found) begin
            state_d = BLANK;
            owner_d = win_idx;
            last_d  = win_idx;
            gnt_d   = 3'b001 << win_idx;
            blank_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = 3'b000;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 3'b000;
        en_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset forces everything back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 2'd2;
      owner_q   <= 2'd0;
      gnt       <= 3'b000;
      disp_en   <= 1'b0;
      disp_data <= 32'h0;
      blank_q   <= '0;
      dwell_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      gnt       <= gnt_d;
      disp_en   <= en_d;
      disp_data <= data_d;
      blank_q   <= blank_d;
      dwell_q   <= dwell_d;
    end
  end

  assign busy = (state_q != IDLE);

endmodule
